// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the layer sequencer slice.
package layer_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, BCAST, WAIT, CAPT, DRAIN} state_t;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index into an array of n entries.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_seq_ctrl_if.sv
// Upstream stream, neuron broadcast/result, and downstream stream signals of one layer.
interface layer_seq_ctrl_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 30
);
  logic [DATA_WIDTH-1:0]             s_data;
  logic                              s_valid;
  logic                              s_ready;
  logic [DATA_WIDTH-1:0]             n_input;
  logic                              n_input_valid;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] n_out;
  logic [NUM_NEURONS-1:0]            n_outvalid;
  logic [DATA_WIDTH-1:0]             m_data;
  logic                              m_valid;
  logic                              m_ready;
  logic                              m_last;

  modport slave (
    input  s_data, s_valid, n_out, n_outvalid, m_ready,
    output s_ready, n_input, n_input_valid, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, n_out, n_outvalid, m_ready,
    input  s_ready, n_input, n_input_valid, m_data, m_valid, m_last
  );
endinterface

// File: rtl/layer_in_buf.sv
// Input vector buffer: simple dual-port RAM, synchronous write, registered read.
module layer_in_buf
  import layer_seq_pkg::*;
#(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     wadd,
  input  logic [DATA_WIDTH-1:0] win,
  input  logic                  ren,
  input  logic [ADDR_W-1:0]     radd,
  output logic [DATA_WIDTH-1:0] rout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[wadd] <= win;
    if (ren) rout <= mem[radd];
  end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Per-layer sequencer: buffer input vector, broadcast to neurons, capture results, serialise out.
module layer_seq_ctrl
  import layer_seq_pkg::*;
#(
  parameter int NUM_INPUTS   = 784,
  parameter int NUM_NEURONS  = 30,
  parameter int DATA_WIDTH   = 16,
  parameter int CAPTURE_DLY  = 1,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  layer_seq_ctrl_if.slave  bus,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W  = cnt_w(NUM_INPUTS);
  localparam int ADDR_W = idx_w(NUM_INPUTS);
  localparam int OIDX_W = cnt_w(NUM_NEURONS);
  localparam int OSEL_W = idx_w(NUM_NEURONS);
  localparam int TMO_W  = cnt_w(WAIT_TIMEOUT);
  localparam int CAP_W  = cnt_w(CAPTURE_DLY);

  state_t                state, state_n;
  logic [CNT_W-1:0]      wr_cnt, rd_cnt;
  logic [OIDX_W-1:0]     oidx;
  logic [TMO_W-1:0]      tmo;
  logic [CAP_W-1:0]      cap_cnt;
  logic                  nvalid;
  logic [DATA_WIDTH-1:0] rout;
  logic [DATA_WIDTH-1:0] out_reg [NUM_NEURONS];

  logic accept, ren, wr_last, rd_last, o_last;
  logic all_ov, any_ov, tmo_hit, cap_last;
  logic capture, clear_out, err_set;

  assign accept   = (state == LOAD) && bus.s_valid;
  assign ren      = (state == BCAST);
  assign wr_last  = (wr_cnt == CNT_W'(NUM_INPUTS - 1));
  assign rd_last  = (rd_cnt == CNT_W'(NUM_INPUTS - 1));
  assign o_last   = (oidx == OIDX_W'(NUM_NEURONS - 1));
  assign all_ov   = &bus.n_outvalid;
  assign any_ov   = |bus.n_outvalid;
  assign tmo_hit  = (tmo == TMO_W'(WAIT_TIMEOUT - 1));
  assign cap_last = (cap_cnt == CAP_W'(CAPTURE_DLY - 1));

  layer_in_buf #(
    .DEPTH      (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk  (clk),
    .wen  (accept),
    .wadd (wr_cnt[ADDR_W-1:0]),
    .win  (bus.s_data),
    .ren  (ren),
    .radd (rd_cnt[ADDR_W-1:0]),
    .rout (rout)
  );

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    clear_out = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE:  state_n = LOAD;
      LOAD:  if (accept && wr_last) state_n = BCAST;
      BCAST: if (rd_last) state_n = WAIT;
      WAIT: begin
        if (any_ov) begin
          err_set = !all_ov;
          // Zero capture delay samples n_out on the same cycle as outvalid.
          if (CAPTURE_DLY == 0) begin
            capture = 1'b1;
            state_n = DRAIN;
          end else begin
            state_n = CAPT;
          end
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          clear_out = 1'b1;
          state_n   = DRAIN;
        end
      end
      CAPT: begin
        if (cap_last) begin
          capture = 1'b1;
          state_n = DRAIN;
        end
      end
      DRAIN: if (bus.m_ready && o_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (any_ov && (state != WAIT) && (state != CAPT)) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      oidx    <= '0;
      tmo     <= '0;
      cap_cnt <= '0;
      nvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state  <= state_n;
      nvalid <= ren;
      err    <= err | err_set;
      if (accept) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (ren) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      tmo     <= (state == WAIT) ? tmo + 1'b1 : '0;
      cap_cnt <= (state == CAPT) ? cap_cnt + 1'b1 : '0;
      if ((state == DRAIN) && bus.m_ready) oidx <= o_last ? '0 : oidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
      if (capture) out_reg[k] <= bus.n_out[k*DATA_WIDTH +: DATA_WIDTH];
      else if (clear_out) out_reg[k] <= '0;
    end
  end

  assign bus.s_ready       = (state == LOAD);
  assign bus.n_input_valid = nvalid;
  assign bus.n_input       = nvalid ? rout : '0;
  assign bus.m_valid       = (state == DRAIN);
  assign bus.m_data        = (state == DRAIN) ? out_reg[oidx[OSEL_W-1:0]] : '0;
  assign bus.m_last        = (state == DRAIN) && o_last;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Randomised self-checking bench for layer_seq_ctrl against a transaction-level model.
module tb_layer_seq_ctrl;

  localparam int NI  = 4;
  localparam int NN  = 3;
  localparam int DW  = 16;
  localparam int CD  = 1;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy, err;

  always #5 clk = ~clk;

  layer_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) bus ();

  layer_seq_ctrl #(
    .NUM_INPUTS   (NI),
    .NUM_NEURONS  (NN),
    .DATA_WIDTH   (DW),
    .CAPTURE_DLY  (CD),
    .WAIT_TIMEOUT (TMO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [DW-1:0] vec  [NI];
  logic [DW-1:0] outs [NN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.n_outvalid = '0;
    step();
    rst = 1'b0;
    #1;
    check("err_after_rst", 32'(err), 32'd0);
    check("busy_after_rst", 32'(busy), 32'd0);
    step();
  endtask

  // vmode: 0 continuous, 1 every other cycle, 2 random s_valid.
  // nmode: 0 all outvalid, 1 no outvalid (timeout), 2 partial outvalid.
  task automatic run_vector(input int vmode, input int nmode, input int stall_after,
                            input bit rnd_ready, input int abort_at);
    logic [DW-1:0] bc [$];
    logic [DW-1:0] dr [$];
    logic [NN-1:0] ov_pat;
    logic [DW-1:0] pd;
    logic [DW-1:0] exp_v;
    int idx, ov_wait, last_bc, err_rise, stall_cnt;
    bit bc_on, bc_done, gap, pv, pr, done, rdy;
    idx = 0; ov_wait = -1; last_bc = -1; err_rise = -1; stall_cnt = 0;
    bc_on = 0; bc_done = 0; gap = 0; pv = 0; pr = 1; done = 0; pd = '0;
    ov_pat = (nmode == 2) ? {1'b0, {(NN-1){1'b1}}} : '1;
    for (int k = 0; k < NN; k++) bus.n_out[k*DW +: DW] = outs[k];

    for (int it = 0; it < 400 && !done; it++) begin
      bus.s_valid = (idx < NI) && ((vmode == 0) || (vmode == 1 && (cyc % 2 == 0)) ||
                                   (vmode == 2 && $urandom_range(0, 1) == 1));
      bus.s_data  = (idx < NI) ? vec[idx] : '0;
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (dr.size() == stall_after && stall_cnt < 3) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      bus.m_ready    = rdy;
      bus.n_outvalid = (nmode != 1 && ov_wait == 3) ? ov_pat : '0;
      if (abort_at > 0 && bc.size() == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check("abort_nvalid", 32'(bus.n_input_valid), 32'd0);
        check("abort_ninput", 32'(bus.n_input), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mvalid", 32'(bus.m_valid), 32'd0);
        step();
        return;
      end
      #1;
      if (bus.s_valid && bus.s_ready) idx++;
      if (bus.n_input_valid) begin
        if (bc_done) gap = 1;
        bc.push_back(bus.n_input);
        bc_on = 1;
        last_bc = cyc;
      end else if (bc_on && !bc_done) begin
        bc_done = 1;
        ov_wait = 0;
      end else if (bc_done) begin
        ov_wait++;
      end
      if (err && err_rise < 0) err_rise = cyc;
      if (pv && !pr) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data", 32'(bus.m_data), 32'(pd));
      end
      if (bus.m_valid) begin
        check("m_last", 32'(bus.m_last), 32'(dr.size() == NN - 1));
        if (bus.m_ready) dr.push_back(bus.m_data);
      end
      pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data;
      if (dr.size() == NN) done = 1;
      step();
    end

    bus.s_valid = 1'b0;
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sready", 32'(bus.s_ready), 32'd0);
    check("idle_mvalid", 32'(bus.m_valid), 32'd0);
    step();
    #1;
    check("reload_sready", 32'(bus.s_ready), 32'd1);
    step();

    check("bc_count", 32'(bc.size()), 32'(NI));
    check("bc_gap", 32'(gap), 32'd0);
    for (int i = 0; i < NI && i < bc.size(); i++) check("bc_data", 32'(bc[i]), 32'(vec[i]));
    check("drain_count", 32'(dr.size()), 32'(NN));
    for (int i = 0; i < NN && i < dr.size(); i++) begin
      exp_v = (nmode == 1) ? '0 : outs[i];
      check("drain_data", 32'(dr[i]), 32'(exp_v));
    end
    check("err_flag", 32'(err), 32'(nmode != 0));
    if (nmode == 1) check("tmo_err_cycle", 32'(err_rise), 32'(last_bc + TMO));
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NI; i++) vec[i] = DW'($urandom);
  endtask

  task automatic rand_outs();
    for (int i = 0; i < NN; i++) outs[i] = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    bus.n_out = '0;
    bus.n_outvalid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 32'(bus.s_ready), 32'd0);
    check("rst_nvalid", 32'(bus.n_input_valid), 32'd0);
    check("rst_ninput", 32'(bus.n_input), 32'd0);
    check("rst_mvalid", 32'(bus.m_valid), 32'd0);
    check("rst_mlast", 32'(bus.m_last), 32'd0);
    check("rst_mdata", 32'(bus.m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NI; i++) vec[i] = DW'(i + 1);
    outs[0] = 16'h10; outs[1] = 16'h20; outs[2] = 16'h30;
    run_vector(0, 0, -1, 0, 0);

    rand_vec();
    run_vector(1, 0, -1, 0, 0);

    rand_vec();
    outs[0] = 16'h10; outs[1] = 16'h20; outs[2] = 16'h30;
    run_vector(0, 0, 1, 0, 0);

    rand_vec();
    rand_outs();
    run_vector(0, 1, -1, 0, 0);
    do_reset();

    rand_vec();
    rand_outs();
    run_vector(0, 2, -1, 0, 0);
    do_reset();

    rand_vec();
    run_vector(0, 0, -1, 0, 2);
    for (int i = 0; i < NI; i++) vec[i] = DW'(i + 5);
    rand_outs();
    run_vector(0, 0, -1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      rand_vec();
      rand_outs();
      run_vector(2, 0, -1, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
Sequencer for one fully-connected layer of neurons. It buffers an incoming input vector, broadcasts it to all neurons of the layer as one contiguous burst, waits for the neurons' result strobe, captures the outputs, and serialises them to the next layer. It sits between two layers and is instantiated once per layer in the top-level network.

Parameters:
- NUM_INPUTS, 784, input vector length; equals the neurons' numWeight.
- NUM_NEURONS, 30, neurons in this layer; equals the output vector length.
- DATA_WIDTH, 16, sample width.
- CAPTURE_DLY, 1, cycles after the all-outvalid cycle at which n_out is sampled (activation ROM latency).
- WAIT_TIMEOUT, 64, maximum cycles in WAIT before flagging an error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_data  in  DATA_WIDTH  upstream sample.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- n_input  out  DATA_WIDTH  broadcast sample to all neurons (myinput).
- n_input_valid  out  1  broadcast valid (myinputValid).
- n_out  in  NUM_NEURONS*DATA_WIDTH  neuron outputs, flattened; neuron k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- n_outvalid  in  NUM_NEURONS  per-neuron outvalid.
- m_data  out  DATA_WIDTH  downstream sample.
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with the final output sample.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: FSM=IDLE; all counters 0; s_ready=0; n_input_valid=0; n_input=0; m_valid=0; m_last=0; m_data=0; busy=0; err=0.
- FSM states: IDLE, LOAD, BCAST, WAIT, CAPT, DRAIN.
- IDLE -> LOAD unconditionally on the next cycle.
- LOAD:
  - s_ready=1.
  - On each s_valid&s_ready, write s_data to buffer[wr_cnt] and increment wr_cnt.
  - When the accepted sample has wr_cnt==NUM_INPUTS-1: go to BCAST, clear wr_cnt, s_ready=0 on the next cycle.
- BCAST:
  - Issue buffer reads at rd_cnt=0..NUM_INPUTS-1 on consecutive cycles; the buffer has 1-cycle read latency.
  - n_input_valid is high for exactly NUM_INPUTS consecutive cycles, with n_input = buffer[i] on the i-th valid cycle. There are no gaps; the neurons detect end of burst from the falling valid.
  - The first n_input_valid occurs 1 cycle after entering BCAST.
  - Enter WAIT on the cycle after the last read is issued; n_input_valid drops 1 cycle later.
- WAIT:
  - Counter tmo increments each cycle.
  - If n_outvalid is all-ones: go to CAPT.
  - If n_outvalid is nonzero but not all-ones: set err, still go to CAPT.
  - If tmo reaches WAIT_TIMEOUT: set err, go to DRAIN, outputs forced to 0.
- CAPT:
  - Wait CAPTURE_DLY cycles (0 allowed: sample in the same cycle as the all-outvalid condition, handled combinationally on the transition).
  - Then latch all of n_out into the output register file out_reg[NUM_NEURONS] and go to DRAIN.
- DRAIN:
  - m_data = out_reg[oidx]; m_valid=1; m_last = (oidx==NUM_NEURONS-1).
  - On m_valid&m_ready, oidx++. m_data/m_valid are held stable while m_ready=0.
  - After the last transfer: m_valid=0, go to IDLE. s_ready rises again 2 cycles after the last handshake (via IDLE).
- n_outvalid outside WAIT/CAPT: ignored, err set.
- s_valid outside LOAD: not accepted, since s_ready=0.
- rst mid-operation returns everything to reset values on the next edge. Buffer contents are not cleared and are don't-care.
- Counter widths:
  - wr_cnt, rd_cnt: $clog2(NUM_INPUTS+1).
  - oidx: $clog2(NUM_NEURONS+1).
  - tmo: $clog2(WAIT_TIMEOUT+1).
  - All counters compare against the parameter with no wrap.
- Throughput: one vector per NUM_INPUTS + NUM_NEURONS + neuron latency + ~6 cycles. No overlap of LOAD and DRAIN.

Decomposition:
- Package layer_seq_pkg: typedef enum logic [2:0] state_t {IDLE, LOAD, BCAST, WAIT, CAPT, DRAIN}; function clog2-based width helpers.
- Sub-module layer_in_buf: simple dual-port RAM, NUM_INPUTS x DATA_WIDTH, synchronous write, registered 1-cycle read. Ports clk, wen, wadd, win, ren, radd, rout.

Test Plan:
1. NUM_INPUTS=4, NUM_NEURONS=3. Send s_data 1,2,3,4 back-to-back -> n_input_valid high exactly 4 consecutive cycles carrying 1,2,3,4. Model neurons raise all outvalid 5 cycles later with outputs 0x10,0x20,0x30 -> m_data 0x10,0x20,0x30, m_last on 0x30, busy returns 0.
2. Same config, s_valid toggling every other cycle in LOAD -> broadcast is still 4 contiguous valid cycles with the correct order.
3. Same config, m_ready low for 3 cycles mid-DRAIN -> m_data holds 0x20 stable, no sample lost or duplicated.
4. No n_outvalid after BCAST, WAIT_TIMEOUT=8 -> err=1 after 8 cycles, DRAIN outputs 0,0,0, then IDLE.
5. n_outvalid=3'b011 in WAIT -> err=1, capture still occurs, outputs drained.
6. Assert rst during BCAST after 2 samples -> next cycle n_input_valid=0, busy=0. A new vector 5,6,7,8 is then broadcast correctly.
